instruction_fetch: RTL

Fetch stage for the single-cycle RISC-V core. It owns the program counter, drives the word address into the combinational instruction ROM, and registers the returned word for decode. It also handles stalls, taken-branch redirects with squash of the wrong-path word, and the halt sentinel (32'hFFFF_FFFF), after which it freezes until reset.

---
 rtl/instruction_fetch.sv | 65 ++++++
 1 files changed

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC owner, ROM addressing, registered fetch with stall, redirect squash and halt sentinel
module instruction_fetch #(
  parameter int ADDR_W = 5,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_instr,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [31:0]       branch_target,
  output logic [31:0]       instr,
  output logic [31:0]       instr_pc,
  output logic              instr_valid,
  output logic              halted
);
  typedef enum logic {RUN, HALT} state_t;
  state_t state, state_d;
  logic [31:0] pc_q, pc_d, instr_d, instr_pc_d;
  logic valid_d;
  logic sentinel;
  assign rom_addr = pc_q[ADDR_W+1:2];
  assign halted   = state == HALT;
  assign sentinel = rom_instr == 32'hFFFF_FFFF;
  always_comb begin
    state_d    = state;
    pc_d       = pc_q;
    instr_d    = instr;
    instr_pc_d = instr_pc;
    valid_d    = instr_valid;
    if (state == HALT) begin
      valid_d = 1'b0;
    end else if (branch_taken) begin
      pc_d    = {branch_target[31:2], 2'b00};
      valid_d = 1'b0;
    end else if (!stall) begin
      if (sentinel) begin
        // the sentinel word is never handed to decode
        state_d = HALT;
        valid_d = 1'b0;
      end else begin
        instr_d    = rom_instr;
        instr_pc_d = pc_q;
        valid_d    = 1'b1;
        pc_d       = pc_q + 32'd4;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      pc_q        <= RESET_PC;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else begin
      state       <= state_d;
      pc_q        <= pc_d;
      instr       <= instr_d;
      instr_pc    <= instr_pc_d;
      instr_valid <= valid_d;
    end
  end
endmodule
